// File: rtl/contador_mod_jk_pkg.sv
// contador_mod_jk_pkg
// Constants shared by the JK-based modulo counter and its flip-flop cells.
//   DIR_UP / DIR_DOWN : values of the counter's 'up' direction input.
//   JK_*              : {J,K} pair encodings understood by ff_jk_r.
package contador_mod_jk_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/contador_mod_jk_ff_jk_r.sv
// ff_jk_r
// Single JK flip-flop cell with asynchronous active-low reset.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, forces Q=0
//   j, k    : JK control pair (hold / reset / set / toggle)
//   Q, Qn   : true and complemented state outputs
import contador_mod_jk_pkg::*;

module ff_jk_r (
    input  logic clock,
    input  logic reset_n,
    input  logic j,
    input  logic k,
    output logic Q,
    output logic Qn
);

    logic r_q;

    // Classic JK behaviour; the reset drops the cell to 0 without waiting for a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   r_q <= r_q;
                JK_RESET:  r_q <= 1'b0;
                JK_SET:    r_q <= 1'b1;
                JK_TOGGLE: r_q <= ~r_q;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign Q  = r_q;
    assign Qn = ~r_q;

endmodule

// File: rtl/contador_mod_jk.sv
// contador_mod_jk
// Synchronous modulo-MOD up/down counter built from one JK flip-flop per bit.
// Default configuration is a BCD decade (0..9).
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (count=0, wrapped=0)
//   clear   : synchronous clear to 0, also clears wrapped (highest priority)
//   load    : synchronous parallel load of d, saturated to MOD-1
//   d       : load value
//   enable  : count enable
//   up      : direction, 1 = up, 0 = down
//   count   : current count, taken straight from the cell Q outputs
//   tc      : combinational terminal count, for enabling the next decade
//   wrapped : sticky flag, set on any wrap-around, cleared by clear/reset
import contador_mod_jk_pkg::*;

module contador_mod_jk #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_wrapEvent;
    logic             r_wrapped;

    // Desired next count. Wraps are decoded explicitly so the +/-1 never
    // overflows; an out-of-range state falls back into the legal sequence.
    always_comb begin
        w_next      = w_q;
        w_wrapEvent = 1'b0;
        if (clear) begin
            w_next = '0;
        end else if (load) begin
            w_next = (d > MAX_VAL) ? MAX_VAL : d;
        end else if (enable) begin
            if (up == DIR_UP) begin
                if (w_q == MAX_VAL) begin
                    w_next      = '0;
                    w_wrapEvent = 1'b1;
                end else if (w_q > MAX_VAL) begin
                    w_next = '0;
                end else begin
                    w_next = w_q + WIDTH'(1);
                end
            end else begin
                if (w_q == '0) begin
                    w_next      = MAX_VAL;
                    w_wrapEvent = 1'b1;
                end else if (w_q > MAX_VAL) begin
                    w_next = MAX_VAL;
                end else begin
                    w_next = w_q - WIDTH'(1);
                end
            end
        end
    end

    // JK excitation: set only bits that must rise, reset only bits that must
    // fall. Holding the count therefore yields J=K=0 on every cell.
    assign w_j = w_qn & w_next;
    assign w_k = w_q & ~w_next;

    for (genvar i = 0; i < WIDTH; i++) begin : gCell
        ff_jk_r u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .j       (w_j[i]),
            .k       (w_k[i]),
            .Q       (w_q[i]),
            .Qn      (w_qn[i])
        );
    end

    // Sticky wrap flag; only clear or reset removes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrapped <= 1'b0;
        end else if (clear) begin
            r_wrapped <= 1'b0;
        end else if (w_wrapEvent) begin
            r_wrapped <= 1'b1;
        end
    end

    assign tc = enable & ~clear & ~load &
                ((up == DIR_UP) ? (w_q == MAX_VAL) : (w_q == '0));

    assign count   = w_q;
    assign wrapped = r_wrapped;

endmodule

// File: tb/tb_contador_mod_jk.sv
// tb_contador_mod_jk
// Self-checking bench for contador_mod_jk (decade configuration). A second
// instance is cascaded on the first one's tc to form a two-digit counter.
module tb_contador_mod_jk;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clock;
    logic             reset_n;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             enable;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;

    logic             clearHi;
    logic [WIDTH-1:0] countHi;
    logic             tcHi;
    logic             wrappedHi;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: plain integers updated by arithmetic rules.
    int mCount   = 0;
    bit mWrapped = 0;
    int mHi      = 0;

    contador_mod_jk #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .load    (load),
        .d       (d),
        .enable  (enable),
        .up      (up),
        .count   (count),
        .tc      (tc),
        .wrapped (wrapped)
    );

    contador_mod_jk #(.WIDTH(WIDTH), .MOD(MOD)) dutHi (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clearHi),
        .load    (1'b0),
        .d       ({WIDTH{1'b0}}),
        .enable  (tc),
        .up      (1'b1),
        .count   (countHi),
        .tc      (tcHi),
        .wrapped (wrappedHi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check tc before the edge, advance the model
    // and check the registered outputs after the edge.
    task automatic applyStimulus(input bit c, input bit l, input int dv, input bit e, input bit u,
                                 input bit cHi = 1'b0);
        bit expTc;
        int nc;
        bit nw;
        int nh;
        logic [31:0] dvBits;
        dvBits  = dv;
        clear   = c;
        load    = l;
        d       = dvBits[WIDTH-1:0];
        enable  = e;
        up      = u;
        clearHi = cHi;
        #1;
        expTc = e && !c && !l && (u ? (mCount == MOD - 1) : (mCount == 0));
        checkOutput("tc", {31'd0, tc}, {31'd0, expTc});
        nc = mCount;
        nw = mWrapped;
        if (c) begin
            nc = 0;
            nw = 0;
        end else if (l) begin
            nc = (dv > MOD - 1) ? MOD - 1 : dv;
        end else if (e) begin
            if (u) begin
                if (mCount == MOD - 1) nw = 1;
                nc = (mCount + 1) % MOD;
            end else begin
                if (mCount == 0) nw = 1;
                nc = (mCount + MOD - 1) % MOD;
            end
        end
        nh = mHi;
        if (cHi) nh = 0;
        else if (expTc) nh = (mHi + 1) % MOD;
        @(posedge clock);
        #1;
        mCount   = nc;
        mWrapped = nw;
        mHi      = nh;
        checkOutput("count", 32'(count), 32'(mCount));
        checkOutput("wrapped", {31'd0, wrapped}, {31'd0, mWrapped});
        checkOutput("countHi", 32'(countHi), 32'(mHi));
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        load    = 1'b0;
        d       = '0;
        enable  = 1'b0;
        up      = 1'b1;
        clearHi = 1'b0;

        // Reset state
        #12;
        checkOutput("resetCount", 32'(count), 32'd0);
        checkOutput("resetWrapped", {31'd0, wrapped}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Count up through the decade wrap: 1..9,0,1,2
        $display("[TB] count up");
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 1);

        // Count down through 0 -> 9
        $display("[TB] count down");
        applyStimulus(0, 1, 2, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);

        // Load priority, saturation, clear over load
        $display("[TB] load and clear");
        applyStimulus(0, 1, 7, 1, 1);
        applyStimulus(0, 1, 13, 1, 1);
        applyStimulus(1, 1, 5, 1, 1);
        checkOutput("clearWrapped", {31'd0, wrapped}, 32'd0);

        // Hold: every cell sees J=K=0
        $display("[TB] hold");
        applyStimulus(0, 1, 5, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput("holdJ", 32'(dut.w_j), 32'd0);
            checkOutput("holdK", 32'(dut.w_k), 32'd0);
        end

        // Asynchronous reset between edges
        $display("[TB] async reset");
        applyStimulus(0, 1, 6, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        #1;
        reset_n = 1'b0;
        #1;
        mCount   = 0;
        mWrapped = 0;
        mHi      = 0;
        checkOutput("asyncCount", 32'(count), 32'd0);
        checkOutput("asyncWrapped", {31'd0, wrapped}, 32'd0);
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("afterReset", 32'(count), 32'd1);

        // Cascade: 100 edges bring the two-digit count back to 00
        $display("[TB] cascade");
        applyStimulus(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("cascadeLo", 32'(count), 32'd0);
        checkOutput("cascadeHi", 32'(countHi), 32'd0);

        // Randomized traffic against the model
        $display("[TB] random");
        for (int i = 0; i < 300; i++) begin
            bit rc, rl, re, ru;
            int rd;
            rc = ($urandom_range(0, 99) < 5);
            rl = ($urandom_range(0, 99) < 15);
            re = ($urandom_range(0, 99) < 80);
            ru = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 15);
            applyStimulus(rc, rl, rd, re, ru);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/contador_mod_jk.md
Name: contador_mod_jk

Overview:
Synchronous modulo-MOD up/down counter built from JK flip-flop cells, one cell per bit. It is the consumer stage of the JK flip-flop. Default configuration is a 4-bit BCD decade counter (0..9). It supports parallel load, count enable and a cascade output for chaining decades. Each cell's J/K pair is driven by excitation logic derived from the desired next state, so the JK behaviour (hold/reset/set/toggle) is exercised in a real datapath.

Parameters:
WIDTH, 4, counter width in bits; must satisfy 2**WIDTH >= MOD.
MOD, 10, count modulus; legal range 2..2**WIDTH; sequence is 0..MOD-1.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous clear to 0.
load  input  1  synchronous parallel load.
d  input  WIDTH  load value.
enable  input  1  count enable.
up  input  1  direction: 1 = up, 0 = down.
count  output  WIDTH  current count, taken from the cell Q outputs.
tc  output  1  terminal count, combinational, for cascading.
wrapped  output  1  registered, sticky wrap-around flag.

Behaviour:
- Reset: reset_n=0 forces count=0 and wrapped=0 immediately, independent of clock. Reset asserted mid-count aborts the operation with no pending state. First update happens on the first rising edge after reset_n rises.
- Priority per rising edge, highest first: clear > load > enable count > hold.
- clear=1: next=0 and wrapped<=0.
- load=1: next=d if d<=MOD-1, else next=MOD-1 (saturate); wrapped unchanged.
- enable=1, up=1: next=count+1; at count==MOD-1, next=0 and wrapped<=1.
- enable=1, up=0: next=count-1; at count==0, next=MOD-1 and wrapped<=1.
- enable=0, no clear, no load: hold; all cells receive J=K=0.
- Excitation per bit i: J_i = ~q_i & next_i, K_i = q_i & ~next_i. Never apply J=K=1 except when a toggle is required.
- Latency: count reflects a command one clock edge after it is sampled. No combinational path from inputs to count.
- tc = enable & ~clear & ~load & (up ? count==MOD-1 : count==0). tc is high in the same cycle in which the wrap edge occurs.
- Width rules: comparisons use WIDTH-bit unsigned values, with MOD-1 as a WIDTH-bit constant. No arithmetic overflow is possible because wrap is decoded explicitly.
- Out-of-range state (count>=MOD, unreachable in normal use): next count up goes to 0; next count down goes to MOD-1.
- wrapped stays 1 until clear or reset.

Decomposition:
- Shared package: direction constants DIR_UP=1, DIR_DOWN=0; the JK encoding constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
- One sub-module: ff_jk_r, a JK flip-flop with asynchronous active-low reset (ports clock, reset_n, j, k, Q, Qn). Instantiated WIDTH times via generate.
- Top level contains only next-state/excitation logic, tc decode and the wrapped register.

Test Plan:
1. Reset then count up: reset_n pulse low, enable=1, up=1, 12 edges -> count 1,2,...,9,0,1,2. tc=1 only while count=9. wrapped=1 after the 9->0 edge.
2. Count down wrap: load d=2, then enable=1, up=0, 4 edges -> count 2,1,0,9,8. tc=1 while count=0.
3. Load priority and saturation: enable=1, load=1, d=7 -> count=7 (no increment). Then load d=13 -> count=9. Then clear=1 together with load=1 -> count=0 and wrapped=0.
4. Hold: count=5, enable=0 for 5 edges -> count stays 5, tc=0. Probe all cells: J=K=0.
5. Async reset mid-operation: count=6, assert reset_n=0 between edges -> count=0 and wrapped=0 before the next edge. Release reset with enable=1 -> next edge gives count=1.
6. Cascade: two instances, second with enable=tc of first, up=1, 100 edges from 0 -> combined count returns to 00. Second instance increments only on the first instance's 9->0 edges.
